uart_tx_frame: RTL and testbench

Parametrised UART transmitter that serialises one parallel word per valid/ready handshake into an asynchronous frame on a single `tx` line. The frame is start bit, LSB-first data, optional parity, then one or two stop bits. It is the next-generation transmit block of the UART path: bit period, data width and stop-bit count are parameters, and it supports back-to-back frames without an idle gap. It sits between the data-producing logic and the FPGA pin driver, in the single system clock domain.

---
 rtl/uart_tx_frame.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter; define UART_TX_PARITY_EN to insert a parity bit
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 48,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // Reject parameter values the frame format cannot express
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_frame: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  logic baud_wrap;
  logic last_stop;
  logic accept;

  // Bit-period wrap, final-stop-bit detect and the handshake; ready reopens in the very
  // last stop cycle so a waiting word starts its start bit with no idle gap
  always_comb begin
    baud_wrap = (baud_cnt == BAUD_LAST);
    last_stop = (state == S_STOP) && (stop_idx == STOP_LAST);
    ready     = !rst && ((state == S_IDLE) || (last_stop && baud_wrap));
    accept    = valid && ready;
  end

  // Frame sequencer: every output changes on the edge that starts the bit it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state    <= S_START;
        baud_cnt <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        shreg    <= data_in;
        tx       <= 1'b0;
        busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
        // Parity is taken from the word as accepted, before any shifting
        par_bit  <= (^data_in) ^ (PARITY_ODD != 0);
`endif
      end else begin
        case (state)
          S_IDLE: begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
          end
          default: begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            // Raised one cycle early so the pulse lands on the frame's final cycle
            if (last_stop && (baud_cnt == BAUD_PRE)) begin
              done <= 1'b1;
            end
            if (baud_wrap) begin
              case (state)
                S_START: begin
                  state <= S_DATA;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                end
                S_DATA: begin
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state <= S_PARITY;
                    tx    <= par_bit;
`else
                    state <= S_STOP;
                    tx    <= 1'b1;
`endif
                  end else begin
                    bit_idx <= bit_idx + 1'b1;
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                  end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                  state <= S_STOP;
                  tx    <= 1'b1;
                end
`endif
                S_STOP: begin
                  if (last_stop) begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                  end else begin
                    stop_idx <= stop_idx + 1'b1;
                  end
                end
                default: begin
                  state <= S_IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NINST = 3;
  localparam int PBIT  = 1;
`else
  localparam int NINST = 2;
  localparam int PBIT  = 0;
`endif

  typedef struct {
    int          inst;
    int          start;
    int          nb;
    logic [15:0] bits;
  } item_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [8:0]       din = '0;
  logic [NINST-1:0] valid_w = '0;
  logic [NINST-1:0] ready_w;
  logic [NINST-1:0] tx_w;
  logic [NINST-1:0] busy_w;
  logic [NINST-1:0] done_w;

  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  int    done_seen [NINST] = '{default: 0};
  item_t sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame #(.CLKS_PER_BIT(CPB)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_w[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din[4:0]), .valid(valid_w[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_w[2]),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );
`endif

  function automatic int db_of(input int i);
    return (i == 1) ? 5 : 8;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int podd_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int flen(input int i);
    return (1 + db_of(i) + PBIT + sb_of(i)) * CPB;
  endfunction

  function automatic item_t mk_item(input int i, input logic [8:0] w, input int start);
    item_t it;
    int    n;
    int    ones;
    it.inst  = i;
    it.start = start;
    it.bits  = '0;
    n        = 0;
    ones     = 0;
    it.bits[n] = 1'b0;
    n++;
    for (int b = 0; b < db_of(i); b++) begin
      it.bits[n] = w[b];
      if (w[b]) ones++;
      n++;
    end
    if (PBIT == 1) begin
      it.bits[n] = ((ones % 2) == 1) ^ (podd_of(i) == 1);
      n++;
    end
    for (int s = 0; s < sb_of(i); s++) begin
      it.bits[n] = 1'b1;
      n++;
    end
    it.nb = n;
    return it;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [8:0] w, output int start);
    bit acc;
    acc   = 1'b0;
    start = -1;
    din   = w;
    valid_w[i] = 1'b1;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      if (ready_w[i]) begin
        acc   = 1'b1;
        start = cyc + 1;
        sb_q.push_back(mk_item(i, w, cyc + 1));
      end
      @(posedge clk);
      #1;
    end
    valid_w[i] = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops a frame when its first cycle arrives and checks every cycle of it
  initial begin
    item_t cur;
    int    k;
    int    fl;
    bit    active;
    bit    rst_prev;
    active   = 1'b0;
    k        = 0;
    fl       = 0;
    rst_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        active = 1'b0;
        sb_q.delete();
      end
      if (!active && sb_q.size() > 0) begin
        if (sb_q[0].start < cyc) begin
          check("frame_start_missed", cyc, sb_q[0].start);
          void'(sb_q.pop_front());
        end else if (sb_q[0].start == cyc) begin
          cur    = sb_q.pop_front();
          active = 1'b1;
          k      = 1;
          fl     = cur.nb * CPB;
        end
      end
      for (int i = 0; i < NINST; i++) begin
        if (active && cur.inst == i) begin
          check("tx", tx_w[i], cur.bits[(k - 1) / CPB]);
          check("busy", busy_w[i], 1);
          check("done", done_w[i], k == fl);
          check("ready", ready_w[i], (k == fl) && !rst);
        end else begin
          check("idle_tx", tx_w[i], 1);
          check("idle_busy", busy_w[i], 0);
          check("idle_done", done_w[i], 0);
          check("idle_ready", ready_w[i], !rst);
        end
        if (done_w[i]) done_seen[i]++;
      end
      if (active) begin
        k++;
        if (k > fl) active = 1'b0;
      end
      rst_prev = rst;
    end
  end

  initial begin
    int s1;
    int s2;
    logic [8:0] w;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(6);

    send(0, 9'h055, s1);
    tick(flen(0) + 4);
    check("done_count_single", done_seen[0], 1);

    send(0, 9'h0A3, s1);
    send(0, 9'h00F, s2);
    check("b2b_start_gap", s2 - s1, flen(0));
    for (int n = 0; n < flen(0) + 4; n++) begin
      din = 9'($urandom);
      tick(1);
    end
    check("done_count_b2b", done_seen[0], 3);

    for (int n = 0; n < 3; n++) begin
      w = 9'($urandom);
      send(0, w, s1);
    end
    tick(flen(0) + 4);
    check("done_count_random", done_seen[0], 6);

    send(0, 9'h000, s1);
    for (int n = 0; n < 100 && cyc < s1 + 16; n++) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("done_count_abort", done_seen[0], 6);
    send(0, 9'h0FF, s2);
    tick(flen(0) + 4);
    check("done_count_after_reset", done_seen[0], 7);

    send(1, 9'h01F, s1);
    tick(flen(1) + 4);
    check("done_count_w5s2", done_seen[1], 1);
    send(1, 9'h00A, s1);
    send(1, 9'h015, s2);
    check("b2b_start_gap_w5s2", s2 - s1, flen(1));
    tick(flen(1) + 4);
    check("done_count_w5s2_b2b", done_seen[1], 3);

`ifdef UART_TX_PARITY_EN
    send(0, 9'h007, s1);
    tick(flen(0) + 4);
    check("done_count_par_even", done_seen[0], 8);
    send(2, 9'h007, s1);
    tick(flen(2) + 4);
    check("done_count_par_odd", done_seen[2], 1);
`endif

    check("queue_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
